// File: rtl/tdc_reg_write.sv
// TDC configuration-register writer: sequences CSN/WRN (and optional RDN readback) for one register write.
// Latency: CSN falls on the second clk edge counting the edge that first samples write high; all outputs registered.
// Backpressure: none; a request arriving while busy (including the done cycle) is dropped and flagged on wr_drop.
//
// Ports: clk, reset_n (async active-low); write/addr_in/data_in request side; data_rd TDC readback bus;
//        addr_out/data_out/data_oe/CSN/WRN/RDN TDC bus side; busy/done/wr_drop/verify_err status.
// Optional feature macro: TDC_WR_VERIFY_EN adds a readback of the written address after the write frame.
module tdc_reg_write #(
    parameter int T_SETUP   = 1,
    parameter int T_PULSE   = 2,
    parameter int T_HOLD    = 1,
    parameter int T_RECOVER = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        write,
    input  logic [3:0]  addr_in,
    input  logic [27:0] data_in,
    input  logic [27:0] data_rd,
    output logic [3:0]  addr_out,
    output logic [27:0] data_out,
    output logic        data_oe,
    output logic        CSN,
    output logic        WRN,
    output logic        RDN,
    output logic        busy,
    output logic        done,
    output logic        wr_drop,
    output logic        verify_err
);

    // Counter reload values: a phase of N cycles loads N-1; zero-length phases are stretched to one cycle.
    localparam logic [3:0] SETUP_LD   = (T_SETUP   < 1) ? 4'd0 : 4'(T_SETUP   - 1);
    localparam logic [3:0] PULSE_LD   = (T_PULSE   < 1) ? 4'd0 : 4'(T_PULSE   - 1);
    localparam logic [3:0] HOLD_LD    = (T_HOLD    < 1) ? 4'd0 : 4'(T_HOLD    - 1);
    localparam logic [3:0] RECOVER_LD = (T_RECOVER < 1) ? 4'd0 : 4'(T_RECOVER - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER,
        S_RD_SETUP, S_RD_STROBE, S_RD_RECOVER
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        wr_r1, wr_r2;
    logic        req_edge;
    logic        accept, drop, finish;
    logic [3:0]  lat_addr, lat_addr_nxt;
    logic [27:0] lat_data, lat_data_nxt;
    logic        csn_d, wrn_d, oe_d, busy_d;
    logic [3:0]  addr_d;
    logic [27:0] data_d;
    logic        cnt_zero;

    assign req_edge = wr_r1 & ~wr_r2;
    assign cnt_zero = (cnt == 4'd0);

`ifdef TDC_WR_VERIFY_EN
    logic sample;
    logic mismatch;
    logic rdn_d;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt - 4'd1;
        accept       = 1'b0;
        drop         = 1'b0;
        finish       = 1'b0;
`ifdef TDC_WR_VERIFY_EN
        sample       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_nxt = cnt;
                // The done cycle is still part of the access, so a request landing there is refused.
                if (req_edge) begin
                    if (done) begin
                        drop = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = S_SETUP;
                        cnt_nxt   = SETUP_LD;
                    end
                end
            end
            S_SETUP: if (cnt_zero) begin
                state_nxt = S_STROBE;
                cnt_nxt   = PULSE_LD;
            end
            S_STROBE: if (cnt_zero) begin
                state_nxt = S_HOLD;
                cnt_nxt   = HOLD_LD;
            end
            S_HOLD: if (cnt_zero) begin
                state_nxt = S_RECOVER;
                cnt_nxt   = RECOVER_LD;
            end
            S_RECOVER: if (cnt_zero) begin
`ifdef TDC_WR_VERIFY_EN
                state_nxt = S_RD_SETUP;
                cnt_nxt   = SETUP_LD;
`else
                state_nxt = S_IDLE;
                finish    = 1'b1;
`endif
            end
`ifdef TDC_WR_VERIFY_EN
            S_RD_SETUP: if (cnt_zero) begin
                state_nxt = S_RD_STROBE;
                cnt_nxt   = PULSE_LD;
            end
            S_RD_STROBE: if (cnt_zero) begin
                state_nxt = S_RD_RECOVER;
                cnt_nxt   = RECOVER_LD;
                sample    = 1'b1;
            end
            S_RD_RECOVER: if (cnt_zero) begin
                state_nxt = S_IDLE;
                finish    = 1'b1;
            end
`endif
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
        if (state != S_IDLE && req_edge) begin
            drop = 1'b1;
        end
    end

    // Bus outputs are decoded from the next state so the registered strobes line up with the state register.
    always_comb begin
        lat_addr_nxt = accept ? addr_in : lat_addr;
        lat_data_nxt = accept ? data_in : lat_data;
        csn_d  = 1'b1;
        wrn_d  = 1'b1;
        oe_d   = 1'b0;
        busy_d = 1'b1;
`ifdef TDC_WR_VERIFY_EN
        rdn_d  = 1'b1;
`endif
        case (state_nxt)
            S_IDLE:   busy_d = 1'b0;
            S_SETUP,
            S_HOLD: begin
                csn_d = 1'b0;
                oe_d  = 1'b1;
            end
            S_STROBE: begin
                csn_d = 1'b0;
                wrn_d = 1'b0;
                oe_d  = 1'b1;
            end
            S_RD_SETUP: csn_d = 1'b0;
            S_RD_STROBE: begin
                csn_d = 1'b0;
`ifdef TDC_WR_VERIFY_EN
                rdn_d = 1'b0;
`endif
            end
            default: ;
        endcase
        addr_d = (state_nxt == S_IDLE) ? 4'd0  : lat_addr_nxt;
        data_d = (state_nxt == S_IDLE) ? 28'd0 : lat_data_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            wr_r1    <= 1'b0;
            wr_r2    <= 1'b0;
            lat_addr <= 4'd0;
            lat_data <= 28'd0;
            addr_out <= 4'd0;
            data_out <= 28'd0;
            data_oe  <= 1'b0;
            CSN      <= 1'b1;
            WRN      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wr_r1    <= write;
            wr_r2    <= wr_r1;
            lat_addr <= lat_addr_nxt;
            lat_data <= lat_data_nxt;
            addr_out <= addr_d;
            data_out <= data_d;
            data_oe  <= oe_d;
            CSN      <= csn_d;
            WRN      <= wrn_d;
            busy     <= busy_d;
            done     <= finish;
            wr_drop  <= drop;
        end
    end

`ifdef TDC_WR_VERIFY_EN
    // Readback result is held internally and only exposed when the access completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RDN        <= 1'b1;
            mismatch   <= 1'b0;
            verify_err <= 1'b0;
        end else begin
            RDN <= rdn_d;
            if (accept) begin
                mismatch   <= 1'b0;
                verify_err <= 1'b0;
            end else begin
                if (sample) begin
                    mismatch <= (data_rd != lat_data);
                end
                if (finish) begin
                    verify_err <= mismatch;
                end
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd  = ^data_rd;
    assign RDN        = 1'b1;
    assign verify_err = 1'b0;
`endif

endmodule
